// File: rtl/fpu_wb_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpu_wb_collector_pkg                                              |
// | Brief   : Shared widths and entry metadata layout for the FP WB collector.  |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

package fpu_wb_collector_pkg;
  // Per-lane fflags are {NV,DZ,OF,UF,NX}, NV in the MSB.
  localparam int c_fflags_w = 5;
  localparam int c_reg_w    = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int c_warp_w   = `DEPTH_WARP;

  typedef struct packed {
    logic [c_reg_w-1:0]  reg_index;
    logic [c_warp_w-1:0] warp_id;
    logic                wvd;
    logic                wxd;
  } wb_meta_t;

  localparam int c_meta_w = $bits(wb_meta_t);

  // Entry layout, MSB to LSB: {result, fflags, vec_mask, meta}
  function automatic int entry_width(input int lanes, input int len);
    return lanes * len + lanes * c_fflags_w + lanes + c_meta_w;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpu_wb_fifo                                                       |
// | Brief   : Register-based FIFO, extra pointer MSB distinguishes full/empty.  |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fpu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: reads are qualified by o_empty downstream.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
endmodule
`default_nettype wire

// File: rtl/fpu_wb_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpu_wb_collector                                                  |
// | Brief   : Buffers FP lane results and steers them to vector/scalar WB.      |
// |           FPU_WB_BYPASS_EN: 0-cycle path from input to ports when empty.    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fpu_wb_collector
  import fpu_wb_collector_pkg::*;
#(
  parameter int EXPWIDTH   = 8,
  parameter int PRECISION  = 24,
  parameter int HARDTHREAD = 4,
  parameter int DEPTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [HARDTHREAD*(EXPWIDTH+PRECISION)-1:0] in_result_i,
  input  logic [HARDTHREAD*5-1:0]                in_fflags_i,
  input  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] in_reg_index_i,
  input  logic [`DEPTH_WARP-1:0]                 in_warp_id_i,
  input  logic [HARDTHREAD-1:0]                  in_vec_mask_i,
  input  logic                                   in_wvd_i,
  input  logic                                   in_wxd_i,
  output logic                                   out_v_valid_o,
  input  logic                                   out_v_ready_i,
  output logic [HARDTHREAD*(EXPWIDTH+PRECISION)-1:0] out_v_data_o,
  output logic [HARDTHREAD-1:0]                  out_v_mask_o,
  output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] out_v_reg_idx_o,
  output logic [`DEPTH_WARP-1:0]                 out_v_warp_id_o,
  output logic                                   out_x_valid_o,
  input  logic                                   out_x_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0]          out_x_data_o,
  output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] out_x_reg_idx_o,
  output logic [`DEPTH_WARP-1:0]                 out_x_warp_id_o,
  output logic [4:0]                             out_fflags_o
);
  localparam int LEN   = EXPWIDTH + PRECISION;
  localparam int RES_W = HARDTHREAD * LEN;
  localparam int FF_W  = HARDTHREAD * c_fflags_w;
  localparam int ENT_W = entry_width(HARDTHREAD, LEN);

  wb_meta_t          w_in_meta;
  wb_meta_t          w_src_meta;
  logic [ENT_W-1:0]  w_in_entry;
  logic [ENT_W-1:0]  w_head_entry;
  logic [ENT_W-1:0]  w_src_entry;
  logic [RES_W-1:0]  w_src_result;
  logic [FF_W-1:0]   w_src_fflags;
  logic [HARDTHREAD-1:0] w_src_mask;
  logic [c_fflags_w-1:0] w_fflags;
  logic w_full, w_empty, w_push, w_pop, w_src_valid, w_consume;
  logic w_v_fire, w_x_fire, w_v_ok, w_x_ok;
  logic r_v_done, r_x_done;

  assign w_in_meta  = '{reg_index: in_reg_index_i, warp_id: in_warp_id_i,
                        wvd: in_wvd_i, wxd: in_wxd_i};
  assign w_in_entry = {in_result_i, in_fflags_i, in_vec_mask_i, w_in_meta};

  fpu_wb_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_in_entry),
    .o_rdata (w_head_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // In bypass, an input that fully handshakes while empty never enters the FIFO.
`ifdef FPU_WB_BYPASS_EN
  assign w_src_entry = w_empty ? w_in_entry : w_head_entry;
  assign w_src_valid = w_empty ? in_valid_i : 1'b1;
  assign w_push      = in_valid_i && !w_full && !(w_empty && w_consume);
  assign w_pop       = !w_empty && w_consume;
`else
  assign w_src_entry = w_head_entry;
  assign w_src_valid = !w_empty;
  assign w_push      = in_valid_i && !w_full;
  assign w_pop       = w_consume;
`endif

  assign {w_src_result, w_src_fflags, w_src_mask, w_src_meta} = w_src_entry;

  assign out_v_valid_o = w_src_valid && w_src_meta.wvd && !r_v_done;
  assign out_x_valid_o = w_src_valid && w_src_meta.wxd && !r_x_done;
  assign w_v_fire      = out_v_valid_o && out_v_ready_i;
  assign w_x_fire      = out_x_valid_o && out_x_ready_i;
  assign w_v_ok        = !w_src_meta.wvd || r_v_done || w_v_fire;
  assign w_x_ok        = !w_src_meta.wxd || r_x_done || w_x_fire;
  assign w_consume     = w_src_valid && w_v_ok && w_x_ok;
  assign in_ready_o    = !w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_done <= 1'b0;
      r_x_done <= 1'b0;
    end else if (w_consume) begin
      r_v_done <= 1'b0;
      r_x_done <= 1'b0;
    end else if (w_src_valid) begin
      r_v_done <= r_v_done | w_v_fire;
      r_x_done <= r_x_done | w_x_fire;
    end
  end

  always_comb begin
    w_fflags = '0;
    for (int i = 0; i < HARDTHREAD; i++) begin
      if (w_src_mask[i]) w_fflags = w_fflags | w_src_fflags[i*c_fflags_w +: c_fflags_w];
    end
  end

  assign out_v_data_o    = w_src_valid ? w_src_result         : '0;
  assign out_v_mask_o    = w_src_valid ? w_src_mask           : '0;
  assign out_v_reg_idx_o = w_src_valid ? w_src_meta.reg_index : '0;
  assign out_v_warp_id_o = w_src_valid ? w_src_meta.warp_id   : '0;
  assign out_x_data_o    = w_src_valid ? w_src_result[LEN-1:0] : '0;
  assign out_x_reg_idx_o = w_src_valid ? w_src_meta.reg_index : '0;
  assign out_x_warp_id_o = w_src_valid ? w_src_meta.warp_id   : '0;
  assign out_fflags_o    = w_src_valid ? w_fflags             : '0;
endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_collector.sv
`default_nettype none
// Testbench for fpu_wb_collector: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
module tb_fpu_wb_collector;
  localparam int LEN   = 32;
  localparam int HT    = 4;
  localparam int DEPTH = 4;
  localparam int RW    = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int WW    = `DEPTH_WARP;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_wvd, in_wxd;
  logic [HT*LEN-1:0] in_result;
  logic [HT*5-1:0]   in_fflags;
  logic [RW-1:0]     in_reg_index;
  logic [WW-1:0]     in_warp_id;
  logic [HT-1:0]     in_vec_mask;
  logic v_valid, v_ready, x_valid, x_ready;
  logic [HT*LEN-1:0] v_data;
  logic [HT-1:0]     v_mask;
  logic [RW-1:0]     v_reg_idx, x_reg_idx;
  logic [WW-1:0]     v_warp_id, x_warp_id;
  logic [LEN-1:0]    x_data;
  logic [4:0]        fflags;

  always #5 clk = ~clk;

  fpu_wb_collector dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
    .in_fflags_i(in_fflags), .in_reg_index_i(in_reg_index), .in_warp_id_i(in_warp_id),
    .in_vec_mask_i(in_vec_mask), .in_wvd_i(in_wvd), .in_wxd_i(in_wxd),
    .out_v_valid_o(v_valid), .out_v_ready_i(v_ready), .out_v_data_o(v_data),
    .out_v_mask_o(v_mask), .out_v_reg_idx_o(v_reg_idx), .out_v_warp_id_o(v_warp_id),
    .out_x_valid_o(x_valid), .out_x_ready_i(x_ready), .out_x_data_o(x_data),
    .out_x_reg_idx_o(x_reg_idx), .out_x_warp_id_o(x_warp_id), .out_fflags_o(fflags)
  );

  typedef struct {
    logic [HT*LEN-1:0] res;
    logic [HT*5-1:0]   ff;
    logic [RW-1:0]     ri;
    logic [WW-1:0]     wid;
    logic [HT-1:0]     mask;
    logic              wvd;
    logic              wxd;
  } ent_t;

  ent_t q[$];
  bit   m_vdone, m_xdone;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [HT*LEN-1:0] act, input logic [HT*LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ff_or(input ent_t e);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < HT; i++) if (e.mask[i]) r = r | e.ff[i*5 +: 5];
    return r;
  endfunction

  // Reference model: a queue of pending entries plus per-port "already written" flags.
  always @(posedge clk or posedge rst) begin
    ent_t e;
    bit   can_push, vf, xf;
    if (rst) begin
      q.delete();
      m_vdone = 0;
      m_xdone = 0;
    end else begin
      can_push = in_valid && (q.size() < DEPTH);
      e = '{res: in_result, ff: in_fflags, ri: in_reg_index, wid: in_warp_id,
            mask: in_vec_mask, wvd: in_wvd, wxd: in_wxd};
      if (q.size() > 0) begin
        vf = q[0].wvd && !m_vdone && v_ready;
        xf = q[0].wxd && !m_xdone && x_ready;
        if ((!q[0].wvd || m_vdone || vf) && (!q[0].wxd || m_xdone || xf)) begin
          void'(q.pop_front());
          m_vdone = 0;
          m_xdone = 0;
        end else begin
          m_vdone = m_vdone | vf;
          m_xdone = m_xdone | xf;
        end
      end
      if (can_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    ent_t h;
    check("m_in_ready", in_ready, q.size() < DEPTH);
    if (q.size() == 0) begin
      check("m_v_valid_empty", v_valid, 0);
      check("m_x_valid_empty", x_valid, 0);
      check("m_fflags_empty", fflags, 0);
    end else begin
      h = q[0];
      check("m_v_valid", v_valid, h.wvd && !m_vdone);
      check("m_x_valid", x_valid, h.wxd && !m_xdone);
      check("m_fflags", fflags, ff_or(h));
      check("m_v_data", v_data, h.res);
      check("m_v_mask", v_mask, h.mask);
      check("m_v_reg_idx", v_reg_idx, h.ri);
      check("m_v_warp_id", v_warp_id, h.wid);
      check("m_x_data", x_data, h.res[LEN-1:0]);
      check("m_x_reg_idx", x_reg_idx, h.ri);
      check("m_x_warp_id", x_warp_id, h.wid);
    end
  end

  function automatic ent_t mk(input int seed, input logic wvd, input logic wxd, input logic [HT-1:0] mask);
    ent_t e;
    for (int i = 0; i < HT; i++) e.res[i*LEN +: LEN] = 32'(32'hA000_0000 + seed * 16 + i);
    e.ff   = 20'(seed * 37 + 5);
    e.ri   = RW'(seed);
    e.wid  = WW'(seed + 1);
    e.mask = mask;
    e.wvd  = wvd;
    e.wxd  = wxd;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ent_t e);
    in_valid = 1'b1;
    in_result = e.res; in_fflags = e.ff; in_reg_index = e.ri;
    in_warp_id = e.wid; in_vec_mask = e.mask; in_wvd = e.wvd; in_wxd = e.wxd;
  endtask

  initial begin
    ent_t a, b, c, d, e, f;
    rst = 1'b1; in_valid = 0; v_ready = 0; x_ready = 0;
    in_result = '0; in_fflags = '0; in_reg_index = '0; in_warp_id = '0;
    in_vec_mask = '0; in_wvd = 0; in_wxd = 0;
    #1;
    check("rst_v_valid", v_valid, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_v_data", v_data, 0);
    check("rst_fflags", fflags, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: vector-only entry, one cycle of latency
    v_ready = 1;
    a = mk(1, 1, 0, 4'b1111);
    drive(a);
    @(negedge clk);
    check("t1_no_bypass", v_valid, 0);
    tick(); in_valid = 0;
    @(negedge clk);
    check("t1_v_valid", v_valid, 1);
    check("t1_v_data", v_data, a.res);
    check("t1_v_idx", v_reg_idx, a.ri);
    check("t1_x_valid", x_valid, 0);
    tick(); tick();

    // 2: both ports, scalar stalled for three cycles
    v_ready = 1; x_ready = 0;
    b = mk(2, 1, 1, 4'b1111);
    drive(b); tick(); in_valid = 0;
    @(negedge clk);
    check("t2_v_valid0", v_valid, 1);
    check("t2_x_valid0", x_valid, 1);
    tick();
    @(negedge clk);
    check("t2_v_done", v_valid, 0);
    check("t2_x_pending", x_valid, 1);
    check("t2_x_data", x_data, b.res[LEN-1:0]);
    tick(); tick();
    x_ready = 1;
    @(negedge clk);
    check("t2_x_still", x_valid, 1);
    tick();
    @(negedge clk);
    check("t2_popped", x_valid, 0);
    tick();

    // 3: fill to DEPTH with readys low, then one pop
    v_ready = 0; x_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(mk(10 + i, 1, 0, 4'b1111)); tick();
    end
    in_valid = 0;
    @(negedge clk);
    check("t3_full", in_ready, 0);
    drive(mk(20, 1, 0, 4'b1111)); tick();
    in_valid = 0; v_ready = 1;
    tick();
    @(negedge clk);
    check("t3_ready_again", in_ready, 1);
    check("t3_head", v_data, mk(11, 1, 0, 4'b1111).res);
    for (int i = 0; i < DEPTH; i++) tick();

    // 4: fflags reduction over masked lanes, held stable under stall
    v_ready = 0;
    c = mk(30, 1, 0, 4'b0101);
    c.ff = {5'b01000, 5'b10000, 5'b00100, 5'b00001};
    drive(c); tick(); in_valid = 0;
    @(negedge clk);
    check("t4_fflags", fflags, 5'b10001);
    tick();
    @(negedge clk);
    check("t4_fflags_hold", fflags, 5'b10001);
    check("t4_hold_valid", v_valid, 1);
    v_ready = 1; tick();
    c = mk(31, 1, 0, 4'b0000);
    c.ff = '1;
    v_ready = 0;
    drive(c); tick(); in_valid = 0;
    @(negedge clk);
    check("t4_mask0_valid", v_valid, 1);
    check("t4_mask0_mask", v_mask, 0);
    check("t4_mask0_fflags", fflags, 0);
    v_ready = 1; tick(); tick();

    // 5: silent entry followed by a vector entry
    d = mk(40, 0, 0, 4'b1111);
    e = mk(41, 1, 0, 4'b1111);
    drive(d); tick();
    drive(e);
    @(negedge clk);
    check("t5_silent_v", v_valid, 0);
    check("t5_silent_x", x_valid, 0);
    tick(); in_valid = 0;
    @(negedge clk);
    check("t5_second_v", v_valid, 1);
    check("t5_second_data", v_data, e.res);
    tick(); tick();

    // 6: reset with a full queue, then a fresh push
    v_ready = 0; x_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(mk(50 + i, 1, 1, 4'b1111)); tick();
    end
    in_valid = 0;
    rst = 1'b1;
    #1;
    check("t6_rst_v", v_valid, 0);
    check("t6_rst_x", x_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    v_ready = 1; x_ready = 1;
    f = mk(60, 1, 1, 4'b0011);
    drive(f); tick(); in_valid = 0;
    @(negedge clk);
    check("t6_post_v", v_valid, 1);
    check("t6_post_x", x_valid, 1);
    check("t6_post_xdata", x_data, f.res[LEN-1:0]);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
